// File: rtl/line_fill_mem_responder_pkg.sv
// Shared definitions for the line-side memory responder and the cache controller:
// bus widths, burst geometry, FSM state encoding and a beat helper.
package line_fill_pkg;

  localparam int DATA_W = 32;
  localparam int LINE_W = 4;
  localparam int BEATS  = 4;
  localparam int BEAT_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBURST = 2'd1,
    RWAIT  = 2'd2,
    RBURST = 2'd3
  } lf_state_t;

  // True when the beat index addresses the final word of a line.
  function automatic logic is_last_beat(input logic [BEAT_W-1:0] beat);
    return (beat == BEAT_W'(BEATS - 1));
  endfunction

endpackage

// File: rtl/line_fill_mem_responder_burst_beat_counter.sv
// Beat index within a line burst. Clear has priority over increment; the
// 2-bit count wraps from the last beat back to 0 at the end of a burst.
module burst_beat_counter
  import line_fill_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_inc,
  output logic [BEAT_W-1:0] o_beat,
  output logic              o_last
);

  logic [BEAT_W-1:0] r_beat;

  // Beat register: cleared on reset or request accept, advanced per transferred beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat <= {BEAT_W{1'b0}};
    end else if (i_clear) begin
      r_beat <= {BEAT_W{1'b0}};
    end else if (i_inc) begin
      r_beat <= r_beat + BEAT_W'(1);
    end else begin
      r_beat <= r_beat;
    end
  end

  assign o_beat = r_beat;
  assign o_last = is_last_beat(r_beat);

endmodule

// File: rtl/line_fill_mem_responder.sv
// Backing memory on the line side of the direct-mapped cache. Holds 16 lines of
// 4 words and serves whole-line write bursts and latency-programmable read bursts.
// All outputs come straight from registers.
module line_fill_mem_responder
  import line_fill_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LINE_W     = 4,
  parameter int BEATS      = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [LINE_W-1:0] req_line_i,
  input  logic              wvalid_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              wdone_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rlast_o
);

  localparam int          ADDR_W   = LINE_W + BEAT_W;
  localparam int          DEPTH    = (2 ** LINE_W) * BEATS;
  // Counter starts one below the latency so the RWAIT->RBURST edge lands
  // exactly RD_LATENCY edges after the accept edge.
  localparam logic [3:0]  LAT_INIT = 4'(RD_LATENCY - 1);

  // Registered state
  lf_state_t           r_state;
  logic [LINE_W-1:0]   r_line;
  logic [3:0]          r_lat_cnt;
  logic                r_req_ready;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rlast;
  logic                r_wdone;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  // Next-state / control wires
  lf_state_t           w_state_nxt;
  logic [LINE_W-1:0]   w_line_nxt;
  logic [3:0]          w_lat_nxt;
  logic                w_req_ready_nxt;
  logic                w_rvalid_nxt;
  logic [DATA_W-1:0]   w_rdata_nxt;
  logic                w_rlast_nxt;
  logic                w_wdone_nxt;
  logic                w_beat_clr;
  logic                w_beat_inc;
  logic                w_mem_we;
  logic [BEAT_W-1:0]   w_beat;
  logic [BEAT_W-1:0]   w_beat_plus;
  logic                w_beat_last;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [ADDR_W-1:0]   w_rd_first_addr;
  logic [ADDR_W-1:0]   w_rd_next_addr;

  burst_beat_counter u_beat (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_beat_clr),
    .i_inc   (w_beat_inc),
    .o_beat  (w_beat),
    .o_last  (w_beat_last)
  );

  assign w_beat_plus     = w_beat + BEAT_W'(1);
  assign w_wr_addr       = {r_line, w_beat};
  assign w_rd_first_addr = {r_line, {BEAT_W{1'b0}}};
  assign w_rd_next_addr  = {r_line, w_beat_plus};

  // Next-state and next-output decode; every target holds its value unless changed.
  always_comb begin
    w_state_nxt  = r_state;
    w_line_nxt   = r_line;
    w_lat_nxt    = r_lat_cnt;
    w_rvalid_nxt = r_rvalid;
    w_rdata_nxt  = r_rdata;
    w_rlast_nxt  = r_rlast;
    w_wdone_nxt  = 1'b0;
    w_beat_clr   = 1'b0;
    w_beat_inc   = 1'b0;
    w_mem_we     = 1'b0;

    case (r_state)
      IDLE: begin
        if (req_valid_i && r_req_ready) begin
          w_line_nxt = req_line_i;
          w_beat_clr = 1'b1;
          if (req_we_i) begin
            w_state_nxt = WBURST;
          end else begin
            w_state_nxt = RWAIT;
            w_lat_nxt   = LAT_INIT;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end

      WBURST: begin
        if (wvalid_i) begin
          w_mem_we   = 1'b1;
          w_beat_inc = 1'b1;
          if (w_beat_last) begin
            w_state_nxt = IDLE;
            w_wdone_nxt = 1'b1;
          end else begin
            w_state_nxt = WBURST;
          end
        end else begin
          w_state_nxt = WBURST;
        end
      end

      RWAIT: begin
        if (r_lat_cnt == 4'd0) begin
          w_state_nxt  = RBURST;
          w_rvalid_nxt = 1'b1;
          w_rdata_nxt  = r_mem[w_rd_first_addr];
          w_rlast_nxt  = is_last_beat({BEAT_W{1'b0}});
        end else begin
          w_lat_nxt = r_lat_cnt - 4'd1;
        end
      end

      RBURST: begin
        if (r_rvalid && rready_i) begin
          w_beat_inc = 1'b1;
          if (w_beat_last) begin
            w_state_nxt  = IDLE;
            w_rvalid_nxt = 1'b0;
            w_rlast_nxt  = 1'b0;
          end else begin
            w_rdata_nxt  = r_mem[w_rd_next_addr];
            w_rlast_nxt  = is_last_beat(w_beat_plus);
          end
        end else begin
          w_state_nxt = RBURST;
        end
      end

      default: begin
        w_state_nxt  = IDLE;
        w_rvalid_nxt = 1'b0;
        w_rlast_nxt  = 1'b0;
      end
    endcase

    w_req_ready_nxt = (w_state_nxt == IDLE);
  end

  // FSM state, captured request fields, latency counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_line      <= {LINE_W{1'b0}};
      r_lat_cnt   <= 4'd0;
      r_req_ready <= 1'b1;
      r_rvalid    <= 1'b0;
      r_rdata     <= {DATA_W{1'b0}};
      r_rlast     <= 1'b0;
      r_wdone     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_line      <= w_line_nxt;
      r_lat_cnt   <= w_lat_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rvalid    <= w_rvalid_nxt;
      r_rdata     <= w_rdata_nxt;
      r_rlast     <= w_rlast_nxt;
      r_wdone     <= w_wdone_nxt;
    end
  end

  // Line storage: wiped on reset, one word written per accepted write beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else if (w_mem_we) begin
      r_mem[w_wr_addr] <= wdata_i;
    end else begin
      r_mem[w_wr_addr] <= r_mem[w_wr_addr];
    end
  end

  assign req_ready_o = r_req_ready;
  assign rvalid_o    = r_rvalid;
  assign rdata_o     = r_rdata;
  assign rlast_o     = r_rlast;
  assign wdone_o     = r_wdone;

endmodule

// File: tb/tb_line_fill_mem_responder.sv
// Directed bench for line_fill_mem_responder. Three instances share the same
// stimulus; the default (latency 2) instance is checked throughout, the latency
// 3 and latency 1 instances are used for the read-latency scenario.
module tb_line_fill_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [3:0]  req_line;
  logic        wvalid;
  logic [31:0] wdata;
  logic        rready;

  logic        req_ready, wdone, rvalid, rlast;
  logic [31:0] rdata;
  logic        req_ready3, wdone3, rvalid3, rlast3;
  logic [31:0] rdata3;
  logic        req_ready1, wdone1, rvalid1, rlast1;
  logic [31:0] rdata1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  line_fill_mem_responder #(.RD_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_line_i(req_line), .wvalid_i(wvalid), .wdata_i(wdata),
    .wdone_o(wdone), .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata),
    .rlast_o(rlast));

  line_fill_mem_responder #(.RD_LATENCY(3)) dut_l3 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready3),
    .req_we_i(req_we), .req_line_i(req_line), .wvalid_i(wvalid), .wdata_i(wdata),
    .wdone_o(wdone3), .rvalid_o(rvalid3), .rready_i(rready), .rdata_o(rdata3),
    .rlast_o(rlast3));

  line_fill_mem_responder #(.RD_LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready1),
    .req_we_i(req_we), .req_line_i(req_line), .wvalid_i(wvalid), .wdata_i(wdata),
    .wdone_o(wdone1), .rvalid_o(rvalid1), .rready_i(rready), .rdata_o(rdata1),
    .rlast_o(rlast1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a line read and collect the burst with rready held high.
  task automatic do_read(input logic [3:0] line, output logic [3:0][31:0] d,
                         output logic [3:0] l, output logic [3:0] v, output int lat,
                         output logic rv_after, output logic rr_after, output bit to);
    d = '0; l = 4'b0000; v = 4'b0000; rv_after = 1'b1; rr_after = 1'b0; to = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_line = line; rready = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin
      tick();
      lat++;
    end
    if (lat >= 20) begin
      to = 1'b1;
    end else begin
      for (int b = 0; b < 4; b++) begin
        d[b] = rdata; l[b] = rlast; v[b] = rvalid;
        tick();
      end
      rv_after = rvalid;
      rr_after = req_ready;
    end
    for (int e = 0; e < 3; e++) tick();
  endtask

  // Issue a line write; pat gives wvalid per slot, data consumed only on valid slots.
  task automatic do_write(input logic [3:0] line, input logic [3:0][31:0] d,
                          input logic [5:0] pat, input int nslots, input bit hold_req,
                          output int wd_cnt, output int wd_at, output logic [5:0] rdy);
    logic [2:0] k;
    k = 3'd0; wd_cnt = 0; wd_at = -1; rdy = 6'b0;
    req_valid = 1'b1; req_we = 1'b1; req_line = line;
    tick();
    if (hold_req) begin
      req_we = 1'b0;
    end else begin
      req_valid = 1'b0;
    end
    for (int s = 0; s < nslots; s++) begin
      wvalid = pat[s];
      wdata  = pat[s] ? d[k[1:0]] : 32'hDEAD_BEEF;
      if (s == nslots - 1) req_valid = 1'b0;
      tick();
      if (pat[s]) k = k + 3'd1;
      rdy[s] = req_ready;
      if (wdone) begin wd_cnt++; wd_at = s; end
    end
    wvalid = 1'b0; req_valid = 1'b0;
    for (int e = 0; e < 2; e++) begin
      tick();
      if (wdone) begin wd_cnt++; wd_at = nslots + e; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b exp=0", rvalid); end
    checks++; if (rlast !== 1'b0 || wdone !== 1'b0) begin failures++; $display("FAIL rst_rlast_wdone got=%b%b exp=00", rlast, wdone); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    rst = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1 || rvalid !== 1'b0) begin failures++; $display("FAIL post_rst_idle got=%b%b exp=10", req_ready, rvalid); end
  endtask

  task automatic test_read_zero();
    logic [3:0][31:0] d; logic [3:0] l, v; int lat; logic rva, rra; bit to;
    do_read(4'd5, d, l, v, lat, rva, rra, to);
    checks++; if (to) begin failures++; $display("FAIL t1_timeout got=no_rvalid exp=rvalid"); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL t1_latency got=%0d exp=2", lat); end
    for (int b = 0; b < 4; b++) begin
      checks++; if (d[b] !== 32'h0) begin failures++; $display("FAIL t1_beat%0d got=%h exp=0", b, d[b]); end
    end
    checks++; if (l !== 4'b1000 || v !== 4'b1111) begin failures++; $display("FAIL t1_last_valid got=%b/%b exp=1000/1111", l, v); end
    checks++; if (rva !== 1'b0 || rra !== 1'b1) begin failures++; $display("FAIL t1_end got=rv%b rr%b exp=rv0 rr1", rva, rra); end
  endtask

  task automatic test_write_read();
    logic [3:0][31:0] wd, d; logic [3:0] l, v; int lat, cnt, at; logic rva, rra; bit to;
    logic [5:0] rdy;
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
    do_write(4'd2, wd, 6'b001111, 4, 1'b0, cnt, at, rdy);
    checks++; if (cnt !== 1 || at !== 3) begin failures++; $display("FAIL t2_wdone got=cnt%0d at%0d exp=cnt1 at3", cnt, at); end
    checks++; if (rdy[3:0] !== 4'b1000) begin failures++; $display("FAIL t2_req_ready got=%b exp=1000", rdy[3:0]); end
    do_read(4'd2, d, l, v, lat, rva, rra, to);
    checks++; if (to) begin failures++; $display("FAIL t2_timeout got=no_rvalid exp=rvalid"); end
    for (int b = 0; b < 4; b++) begin
      checks++; if (d[b] !== wd[b]) begin failures++; $display("FAIL t2_beat%0d got=%h exp=%h", b, d[b], wd[b]); end
    end
    checks++; if (l !== 4'b1000) begin failures++; $display("FAIL t2_rlast got=%b exp=1000", l); end
  endtask

  task automatic test_latency();
    int l1, l2, l3;
    l1 = -1; l2 = -1; l3 = -1;
    req_valid = 1'b1; req_we = 1'b0; req_line = 4'd2; rready = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (rvalid1 && l1 < 0) l1 = c;
      if (rvalid  && l2 < 0) l2 = c;
      if (rvalid3 && l3 < 0) l3 = c;
    end
    checks++; if (l3 !== 3) begin failures++; $display("FAIL t3_lat3 got=%0d exp=3", l3); end
    checks++; if (l1 !== 1) begin failures++; $display("FAIL t3_lat1 got=%0d exp=1", l1); end
    checks++; if (l2 !== 2) begin failures++; $display("FAIL t3_lat2 got=%0d exp=2", l2); end
    for (int e = 0; e < 6; e++) tick();
  endtask

  task automatic test_stall();
    int w;
    logic [31:0] exp_d;
    req_valid = 1'b1; req_we = 1'b0; req_line = 4'd2; rready = 1'b1;
    tick();
    req_valid = 1'b0;
    w = 0;
    while (!rvalid && w < 20) begin tick(); w++; end
    checks++; if (w >= 20) begin failures++; $display("FAIL t4_timeout got=no_rvalid exp=rvalid"); end
    checks++; if (rdata !== 32'hA0) begin failures++; $display("FAIL t4_beat0 got=%h exp=a0", rdata); end
    tick();
    rready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++;
      if (rdata !== 32'hA1 || rvalid !== 1'b1 || rlast !== 1'b0) begin
        failures++; $display("FAIL t4_hold%0d got=%h v%b l%b exp=a1 v1 l0", s, rdata, rvalid, rlast);
      end
    end
    rready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      exp_d = 32'hA0 + 32'(b);
      checks++;
      if (rdata !== exp_d || rvalid !== 1'b1 || rlast !== (b == 3)) begin
        failures++; $display("FAIL t4_beat%0d got=%h v%b l%b exp=%h", b, rdata, rvalid, rlast, exp_d);
      end
      tick();
    end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL t4_end got=%b exp=0", rvalid); end
    for (int e = 0; e < 3; e++) tick();
  endtask

  task automatic test_gaps();
    logic [3:0][31:0] wd, d; logic [3:0] l, v; int lat, cnt, at; logic rva, rra; bit to;
    logic [5:0] rdy;
    wd[0] = 32'hB0; wd[1] = 32'hB1; wd[2] = 32'hB2; wd[3] = 32'hB3;
    do_write(4'd7, wd, 6'b101101, 6, 1'b1, cnt, at, rdy);
    checks++; if (cnt !== 1 || at !== 5) begin failures++; $display("FAIL t5_wdone got=cnt%0d at%0d exp=cnt1 at5", cnt, at); end
    checks++; if (rdy !== 6'b100000) begin failures++; $display("FAIL t5_req_ready got=%b exp=100000", rdy); end
    for (int e = 0; e < 3; e++) tick();
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL t5_no_accept got=rvalid%b exp=0", rvalid); end
    do_read(4'd7, d, l, v, lat, rva, rra, to);
    for (int b = 0; b < 4; b++) begin
      checks++; if (d[b] !== wd[b]) begin failures++; $display("FAIL t5_beat%0d got=%h exp=%h", b, d[b], wd[b]); end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [3:0][31:0] d; logic [3:0] l, v; int lat; logic rva, rra; bit to;
    req_valid = 1'b1; req_we = 1'b1; req_line = 4'd9;
    tick();
    req_valid = 1'b0;
    wvalid = 1'b1; wdata = 32'hC0; tick();
    wdata = 32'hC1; tick();
    wdata = 32'hC2;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rvalid !== 1'b0 || wdone !== 1'b0 || rlast !== 1'b0 || rdata !== 32'h0) begin
      failures++; $display("FAIL t6_async_rst got=rr%b rv%b wd%b rl%b rd=%h exp=rr1 rv0 wd0 rl0 rd=0",
                           req_ready, rvalid, wdone, rlast, rdata);
    end
    tick(); tick();
    rst = 1'b0; wvalid = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1 || wdone !== 1'b0) begin failures++; $display("FAIL t6_idle got=rr%b wd%b exp=rr1 wd0", req_ready, wdone); end
    do_read(4'd9, d, l, v, lat, rva, rra, to);
    checks++; if (d !== '0 || v !== 4'b1111) begin failures++; $display("FAIL t6_line9 got=%h v%b exp=0 v1111", d, v); end
    do_read(4'd2, d, l, v, lat, rva, rra, to);
    checks++; if (d !== '0 || v !== 4'b1111) begin failures++; $display("FAIL t6_line2 got=%h v%b exp=0 v1111", d, v); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_line = 4'd0;
    wvalid = 1'b0; wdata = 32'h0; rready = 1'b1;
    test_reset();
    test_read_zero();
    test_write_read();
    test_latency();
    test_stall();
    test_gaps();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
